// File: rtl/hdb3_tx_sched.sv
// rtl/hdb3_tx_sched.sv - HDB3 encoder bit scheduler: rate divider, preamble/payload/gap framing, source mux
// Preamble phase is built only when HDB3_TX_SCHED_PREAMBLE_EN is defined.
module hdb3_tx_sched #(
  parameter int          NSRC        = 4,
  parameter int          DIV         = 4,
  parameter int          PRE_EN_LEN  = 8,
  parameter logic [31:0] PRE_PATTERN = 32'hAA,
  parameter int          PAY_LEN     = 32,
  parameter int          GAP_LEN     = 4,
  parameter int          NFRAMES     = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            stop_i,
  input  logic [1:0]      src_sel_i,
  input  logic [NSRC-1:0] src_bit_i,
  output logic [NSRC-1:0] src_shift_o,
  output logic            enc_bit_o,
  output logic            enc_valid_o,
  output logic            busy_o,
  output logic            frame_done_o,
  output logic [15:0]     frame_cnt_o
);

  localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [15:0]   PAY_LAST = 16'(PAY_LEN - 1);
  localparam logic [15:0]   GAP_LAST = (GAP_LEN > 0) ? 16'(GAP_LEN - 1) : 16'd0;
  localparam logic [15:0]   NF       = 16'(NFRAMES);

`ifdef HDB3_TX_SCHED_PREAMBLE_EN
  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_PAY, ST_GAP} state_t;
  localparam state_t        ST_FIRST  = ST_PRE;
  localparam logic [15:0]   PRE_LAST  = 16'(PRE_EN_LEN - 1);
  localparam logic [4:0]    PRE_LAST5 = 5'(PRE_EN_LEN - 1);
  logic [4:0] pre_pos;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_PAY, ST_GAP} state_t;
  localparam state_t        ST_FIRST  = ST_PAY;
  logic pre_unused;
  assign pre_unused = ^{PRE_PATTERN, 32'(PRE_EN_LEN)};
`endif

  state_t         state_q, state_d;
  logic [DW-1:0]  div_cnt_q, div_cnt_d;
  logic [15:0]    bit_idx_q, bit_idx_d;
  logic [1:0]     sel_q, sel_d;
  logic           stop_req_q, stop_req_d;
  logic           busy_q, busy_d;
  logic           enc_bit_q, enc_bit_d;
  logic           enc_valid_q, enc_valid_d;
  logic           frame_done_q, frame_done_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;

  logic accept;
  logic tick;
  logic sel_bit;
  logic phase_bit;
  logic last_bit;
  logic frame_end;
  logic finish;

  // busy_q stays high through the final strobe cycle, which also blocks a same-cycle restart
  assign accept = (state_q == ST_IDLE) && !busy_q && start_i && !stop_i;
  assign tick   = (state_q != ST_IDLE) && (div_cnt_q == DIV_LAST);
  assign finish = stop_req_q || stop_i || ((NFRAMES != 0) && ((frame_cnt_q + 16'd1) == NF));

`ifdef HDB3_TX_SCHED_PREAMBLE_EN
  assign pre_pos = PRE_LAST5 - bit_idx_q[4:0];
`endif

  always_comb begin
    sel_bit = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (sel_q == 2'(k)) sel_bit = src_bit_i[k];
    end
  end

  always_comb begin
    src_shift_o = '0;
    for (int k = 0; k < NSRC; k++) begin
      src_shift_o[k] = tick && (state_q == ST_PAY) && (sel_q == 2'(k));
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    phase_bit = 1'b0;
    last_bit  = 1'b0;
    frame_end = 1'b0;
    case (state_q)
`ifdef HDB3_TX_SCHED_PREAMBLE_EN
      ST_PRE: begin
        phase_bit = PRE_PATTERN[pre_pos];
        last_bit  = (bit_idx_q == PRE_LAST);
      end
`endif
      ST_PAY: begin
        phase_bit = sel_bit;
        last_bit  = (bit_idx_q == PAY_LAST);
      end
      ST_GAP: begin
        last_bit  = (bit_idx_q == GAP_LAST);
      end
      default: ;
    endcase

    if (accept) begin
      state_d   = ST_FIRST;
      bit_idx_d = '0;
    end else if (tick) begin
      bit_idx_d = last_bit ? 16'd0 : bit_idx_q + 16'd1;
      if (last_bit) begin
        case (state_q)
`ifdef HDB3_TX_SCHED_PREAMBLE_EN
          ST_PRE: state_d = ST_PAY;
`endif
          ST_PAY: begin
            if (GAP_LEN > 0) state_d = ST_GAP;
            else             frame_end = 1'b1;
          end
          ST_GAP: frame_end = 1'b1;
          default: ;
        endcase
      end
      if (frame_end) state_d = finish ? ST_IDLE : ST_FIRST;
    end
  end

  always_comb begin
    div_cnt_d    = (accept || tick || (state_q == ST_IDLE)) ? '0 : div_cnt_q + DW'(1);
    busy_d       = accept || (state_q != ST_IDLE);
    sel_d        = sel_q;
    if (accept) sel_d = (int'(src_sel_i) < NSRC) ? src_sel_i : 2'd0;
    stop_req_d   = (state_q != ST_IDLE) && (state_d != ST_IDLE) && (stop_req_q || stop_i);
    enc_valid_d  = tick;
    enc_bit_d    = tick ? phase_bit : ((state_q == ST_IDLE) ? 1'b0 : enc_bit_q);
    frame_done_d = frame_end;
    frame_cnt_d  = frame_cnt_q;
    if (accept)         frame_cnt_d = 16'd0;
    else if (frame_end) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      div_cnt_q    <= '0;
      bit_idx_q    <= '0;
      sel_q        <= '0;
      stop_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      enc_bit_q    <= 1'b0;
      enc_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      bit_idx_q    <= bit_idx_d;
      sel_q        <= sel_d;
      stop_req_q   <= stop_req_d;
      busy_q       <= busy_d;
      enc_bit_q    <= enc_bit_d;
      enc_valid_q  <= enc_valid_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign enc_bit_o    = enc_bit_q;
  assign enc_valid_o  = enc_valid_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;
  assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: doc/hdb3_tx_sched.md
Name: hdb3_tx_sched

Overview:
Bit-rate scheduler and source controller in front of the HDB3 encoder. It generates the encoder bit strobe from a clock divider and frames the serial stream as preamble, then payload, then zero gap. It shares the single encoder input among NSRC test-data sources (fixed-pattern generator, PRBS, external) by issuing a one-hot shift enable to the selected source and muxing its bit. The gap zeros deliberately exercise the encoder's 0000 substitution rules.

Parameters:
NSRC, 4, number of test-data sources (2..4)
DIV, 4, clk cycles per encoder bit (>=1)
PRE_EN_LEN, 8, preamble length in bits (1..32)
PRE_PATTERN, 32'hAA, preamble bits; bit PRE_EN_LEN-1 is sent first
PAY_LEN, 32, payload bits per frame (1..65535)
GAP_LEN, 4, zero bits after payload (0..255; 0 = no gap)
NFRAMES, 0, frames per run; 0 = run until stop

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  level; sampled only in IDLE
stop  in  1  level; requests end of run at next frame boundary
src_sel  in  2  source index; latched on start; values >= NSRC are treated as 0
src_bit  in  NSRC  current output bit of each source
src_shift  out  NSRC  one-hot advance strobe to the selected source
enc_bit  out  1  bit to HDB3 encoder
enc_valid  out  1  one-cycle strobe qualifying enc_bit
busy  out  1  high from start acceptance until return to IDLE
frame_done  out  1  one-cycle pulse at the end of each frame
frame_cnt  out  16  completed frames since start; wraps at 65535->0

Behaviour:
- Reset (async, rst=1): FSM=IDLE. All outputs 0. Divider, bit counter, frame_cnt and stop_req cleared. Reset asserted mid-frame aborts the frame immediately. No frame_done is produced.
- States: IDLE, PRE, PAY, GAP.
- IDLE:
  - start=1 and stop=0 at an edge: latch src_sel, clear div_cnt and frame_cnt, busy=1 next cycle, enter PRE.
  - start=1 and stop=1 together: remain IDLE (stop wins).
- Divider: div_cnt counts 0..DIV-1 while busy. tick=1 when div_cnt==DIV-1. With DIV=1, tick is high every busy cycle.
- On a tick cycle, the bit is registered into enc_bit and enc_valid=1 for exactly one cycle on the next cycle.
  - PRE: enc_bit = PRE_PATTERN[PRE_EN_LEN-1-idx].
  - PAY: enc_bit = src_bit[sel] sampled in the tick cycle. src_shift[sel]=1 combinationally in that same tick cycle only. The source advances on the following edge.
  - GAP: enc_bit=0.
- src_shift is 0 outside PAY ticks and in IDLE.
- bit_idx increments per tick. On the last bit of a phase, the next tick belongs to the next phase (no idle bit slots):
  - PRE -> PAY -> GAP.
  - GAP_LEN=0: PAY -> frame end directly.
- Frame end, on the tick of the last bit:
  - frame_done pulses in the same cycle that enc_valid is high for the last bit.
  - frame_cnt increments in that same cycle.
  - Next state: PRE if continuing; IDLE (busy=0) if stop_req=1 or frame_cnt+1==NFRAMES with NFRAMES!=0.
- stop: an edge with stop=1 while busy sets stop_req (sticky until IDLE). The current frame always completes. stop_req is cleared on entry to IDLE.
- start while busy: ignored. src_sel changes while busy: ignored.
- Latency: DIV+1 cycles from the start edge to the first enc_valid.
- enc_bit holds its last value between strobes and returns to 0 in IDLE.

Optional Feature:
- HDB3_TX_SCHED_PREAMBLE_EN
  - Defined: PRE state and the PRE_PATTERN/PRE_EN_LEN behaviour as above.
  - Undefined: PRE state is not built. Start and frame continuation enter PAY directly. Frame length = PAY_LEN+GAP_LEN bits. PRE_* parameters are ignored.

Test Plan:
- Defaults, macro defined, src_sel=1, src_bit[1] driven by a 32-bit rotating register fed by src_shift[1], start pulse:
  - First enc_valid 5 cycles after the start edge.
  - enc_valid every 4 cycles.
  - First 8 bits 10101010, then the 32 source bits in order, then 0000.
  - frame_done with frame_cnt=1 on bit 44.
- NFRAMES=3, DIV=1:
  - Exactly 132 consecutive enc_valid cycles.
  - frame_done at bits 44, 88, 132.
  - busy drops the cycle after the last strobe; frame_cnt=3.
- stop asserted at payload bit 10 of frame 1 (NFRAMES=0):
  - Frame 1 completes all 44 bits; no further enc_valid.
  - busy=0; frame_cnt=1.
- start and stop high together in IDLE: busy, enc_valid and src_shift stay 0 for 20 cycles.
- rst pulsed mid-payload:
  - All outputs 0 asynchronously, no frame_done, frame_cnt=0.
  - A new start yields the preamble from bit 0.
- Macro undefined, GAP_LEN=0, PAY_LEN=4, src_sel=3 (NSRC=4):
  - Only src_shift[3] toggles.
  - Frames are 4 bits; frame_done every 16 cycles with DIV=4.
